// File: rtl/regbank_read_arbiter_pkg.sv
// regbank_pkg: shared register-bank geometry and arbiter state type
package regbank_pkg;
    localparam int REG_COUNT = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    typedef enum logic {UNLOCKED, LOCKED} arb_state_t;
endpackage

// File: rtl/regbank_read_arbiter_if.sv
// regbank_read_arbiter_if: requester/register-bank read bus for the arbiter
// req/req_lock/req_addr: per-requester request, lock qualifier, packed register index
// gnt: one-hot grant; rd_sel/rd_data: register bank mux select and data
// rsp_valid/rsp_data: one-hot owner strobe and registered data; locked: LOCKED state
interface regbank_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W = regbank_pkg::ADDR_W,
    parameter int DATA_W = regbank_pkg::DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rd_sel;
    logic [DATA_W-1:0]         rd_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      locked;
    modport master (
        output req, req_lock, req_addr, rd_data,
        input  gnt, rd_sel, rsp_valid, rsp_data, locked
    );
    modport slave (
        input  req, req_lock, req_addr, rd_data,
        output gnt, rd_sel, rsp_valid, rsp_data, locked
    );
endinterface

// File: rtl/regbank_read_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req at or after ptr
// req: request vector; ptr: highest-priority index
// winner: granted index; any_valid: at least one request present
module rr_pick #(
    parameter int N = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          any_valid
);
    logic [N-1:0] rot;
    logic [PW:0]  off;
    logic [PW:0]  sum;
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        any_valid = 1'b0;
        // descending scan so the lowest rotated offset is the last write
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = (PW + 1)'(k);
                any_valid = 1'b1;
            end
        end
        sum = {1'b0, ptr} + off;
        winner = (sum >= (PW + 1)'(N)) ? PW'(sum - (PW + 1)'(N)) : PW'(sum);
    end
endmodule

// File: rtl/regbank_read_arbiter.sv
// regbank_read_arbiter: round-robin arbiter with lock sharing one register-bank read port
// clk/rst_n: clock and async active-low reset
// bus: slave side of regbank_read_arbiter_if (requests, grant, bank select/data, responses)
module regbank_read_arbiter
    import regbank_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W = regbank_pkg::ADDR_W
) (
    input logic clk,
    input logic rst_n,
    regbank_read_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    arb_state_t         state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      lock_owner;
    logic [PW-1:0]      s1_owner;
    logic               s1_valid;
    logic [NUM_REQ-1:0] owner_oh;
    logic               owner_hold;
    logic [PW-1:0]      owner_next;
    logic [NUM_REQ-1:0] eligible;
    logic [PW-1:0]      pick_ptr;
    logic [PW-1:0]      winner;
    logic [PW-1:0]      win_next;
    logic               any;
    logic               win_lock;
    always_comb begin
        owner_oh = NUM_REQ'(1) << lock_owner;
        owner_hold = (state == LOCKED) && |(bus.req & owner_oh);
        owner_next = (lock_owner == PW'(NUM_REQ - 1)) ? '0 : lock_owner + 1'b1;
        // a dropped lock owner hands over in the same cycle, scanning from owner+1
        eligible = owner_hold ? owner_oh : bus.req;
        pick_ptr = (state == LOCKED && !owner_hold) ? owner_next : ptr;
        win_next = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        win_lock = bus.req_lock[winner];
        bus.gnt = (any && rst_n) ? NUM_REQ'(1) << winner : '0;
        bus.locked = (state == LOCKED);
    end
    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req       (eligible),
        .ptr       (pick_ptr),
        .winner    (winner),
        .any_valid (any)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNLOCKED;
            ptr <= '0;
            lock_owner <= '0;
            s1_owner <= '0;
            s1_valid <= 1'b0;
            bus.rd_sel <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data <= '0;
        end else begin
            s1_valid <= any;
            if (any) begin
                bus.rd_sel <= bus.req_addr[int'(winner) * ADDR_W +: ADDR_W];
                s1_owner <= winner;
            end
            state <= (any && win_lock) ? LOCKED : UNLOCKED;
            if (any && win_lock) lock_owner <= winner;
            ptr <= (any && !win_lock) ? win_next : pick_ptr;
            bus.rsp_valid <= s1_valid ? NUM_REQ'(1) << s1_owner : '0;
            if (s1_valid) bus.rsp_data <= bus.rd_data;
        end
    end
endmodule

// File: tb/tb_regbank_read_arbiter.sv
// tb_regbank_read_arbiter: directed stimulus with a cycle-history model and literal pins
module tb_regbank_read_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst_n;
    int total = 0;
    int passed = 0;
    logic [31:0] bank [16];
    regbank_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(4), .DATA_W(32)) bus ();
    regbank_read_arbiter #(.NUM_REQ(N), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    assign bus.rd_data = bank[bus.rd_sel];
    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask
    function automatic bit bitof(input int v, input int i);
        return ((v >> i) & 1) == 1;
    endfunction
    // model state: grant history per cycle, round-robin pointer, lock owner
    int ptr_m = 0;
    int lk = -1;
    int sel_m = 0;
    longint data_m = 0;
    int cyc_n = 0;
    int g_own [0:2047];
    int g_addr [0:2047];
    bit rst_seen [0:2047];
    always @(negedge clk) begin
        int w;
        int start;
        int rq;
        int ev_own;
        rq = int'(bus.req);
        if (!rst_n) begin
            ptr_m = 0;
            lk = -1;
            sel_m = 0;
            data_m = 0;
            g_own[cyc_n] = -1;
            rst_seen[cyc_n] = 1'b1;
            chk("rst_gnt", longint'(bus.gnt), 0);
            chk("rst_rsp_valid", longint'(bus.rsp_valid), 0);
            chk("rst_rsp_data", longint'(bus.rsp_data), 0);
            chk("rst_rd_sel", longint'(bus.rd_sel), 0);
            chk("rst_locked", longint'(bus.locked), 0);
        end else begin
            rst_seen[cyc_n] = 1'b0;
            w = -1;
            start = (lk >= 0) ? (lk + 1) % N : ptr_m;
            if (lk >= 0 && bitof(rq, lk)) w = lk;
            else for (int k = 0; k < N; k++) if (w < 0 && bitof(rq, (start + k) % N)) w = (start + k) % N;
            ev_own = (cyc_n >= 2 && g_own[cyc_n-2] >= 0 && !rst_seen[cyc_n-1]) ? g_own[cyc_n-2] : -1;
            if (ev_own >= 0) data_m = longint'(bank[g_addr[cyc_n-2]]);
            chk("gnt", longint'(bus.gnt), (w >= 0) ? longint'(1 << w) : 0);
            chk("rsp_valid", longint'(bus.rsp_valid), (ev_own >= 0) ? longint'(1 << ev_own) : 0);
            chk("rsp_data", longint'(bus.rsp_data), data_m);
            chk("rd_sel", longint'(bus.rd_sel), longint'(sel_m));
            chk("locked", longint'(bus.locked), (lk >= 0) ? 1 : 0);
            g_own[cyc_n] = w;
            g_addr[cyc_n] = (w >= 0) ? (int'(bus.req_addr) >> (4 * w)) & 15 : 0;
            if (w >= 0) begin
                sel_m = g_addr[cyc_n];
                if (bitof(int'(bus.req_lock), w)) begin
                    if (lk >= 0 && w != lk) ptr_m = (lk + 1) % N;
                    lk = w;
                end else begin
                    ptr_m = (w + 1) % N;
                    lk = -1;
                end
            end else if (lk >= 0) begin
                ptr_m = (lk + 1) % N;
                lk = -1;
            end
        end
        cyc_n++;
    end
    task automatic cyc(input logic [3:0] r, input logic [3:0] l);
        @(posedge clk);
        #1;
        bus.req = r;
        bus.req_lock = l;
    endtask
    task automatic settle();
        @(negedge clk);
        #1;
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req = '0;
        bus.req_lock = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 2048; i++) g_own[i] = -1;
        for (int i = 0; i < 16; i++) bank[i] = 32'hA5A5_0000 | (32'h111 * i);
        bank[5] = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        bus.req = '0;
        bus.req_lock = '0;
        bus.req_addr = 16'h4321;
        settle();
        chk("lit_reset_gnt", longint'(bus.gnt), 0);
        chk("lit_reset_rsp_data", longint'(bus.rsp_data), 0);
        chk("lit_reset_locked", longint'(bus.locked), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // single read: requester 2, register 5
        bus.req_addr = 16'h0500;
        cyc(4'b0100, 4'b0000);
        settle();
        chk("lit_t1_gnt", longint'(bus.gnt), 4);
        cyc(4'b0000, 4'b0000);
        settle();
        chk("lit_t1_rd_sel", longint'(bus.rd_sel), 5);
        cyc(4'b0000, 4'b0000);
        settle();
        chk("lit_t1_rsp_valid", longint'(bus.rsp_valid), 4);
        chk("lit_t1_rsp_data", longint'(bus.rsp_data), 32'hDEAD_BEEF);
        // all four requesting from ptr=0
        do_reset();
        bus.req_addr = 16'h4321;
        cyc(4'b1111, 4'b0000);
        settle();
        chk("lit_t2_gnt0", longint'(bus.gnt), 1);
        cyc(4'b1111, 4'b0000);
        cyc(4'b1111, 4'b0000);
        settle();
        chk("lit_t2_rsp_valid", longint'(bus.rsp_valid), 1);
        chk("lit_t2_rsp_data", longint'(bus.rsp_data), 32'hA5A5_0111);
        cyc(4'b1111, 4'b0000);
        settle();
        chk("lit_t2_gnt3", longint'(bus.gnt), 8);
        repeat (3) cyc(4'b0000, 4'b0000);
        // lock: move ptr to 1, then requester 1 locks three reads
        cyc(4'b0001, 4'b0000);
        cyc(4'b1011, 4'b0010);
        settle();
        chk("lit_t3_gnt_lock", longint'(bus.gnt), 2);
        cyc(4'b1011, 4'b0010);
        settle();
        chk("lit_t3_locked", longint'(bus.locked), 1);
        cyc(4'b1011, 4'b0010);
        cyc(4'b1001, 4'b0000);
        settle();
        chk("lit_t3_handover", longint'(bus.gnt), 8);
        chk("lit_t3_locked_handover", longint'(bus.locked), 1);
        cyc(4'b0001, 4'b0000);
        settle();
        chk("lit_t3_gnt_next", longint'(bus.gnt), 1);
        chk("lit_t3_unlocked", longint'(bus.locked), 0);
        // wrap: ptr to 3, then 3 before 0, ptr back to 1
        cyc(4'b0100, 4'b0000);
        cyc(4'b1001, 4'b0000);
        settle();
        chk("lit_t4_gnt3", longint'(bus.gnt), 8);
        cyc(4'b0001, 4'b0000);
        settle();
        chk("lit_t4_gnt0", longint'(bus.gnt), 1);
        cyc(4'b0011, 4'b0000);
        settle();
        chk("lit_t4_ptr1", longint'(bus.gnt), 2);
        cyc(4'b0000, 4'b0000);
        // reset with a read in flight
        bus.req_addr = 16'h4327;
        cyc(4'b0001, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req = '0;
        settle();
        chk("lit_t5_rsp_valid", longint'(bus.rsp_valid), 0);
        chk("lit_t5_rd_sel", longint'(bus.rd_sel), 0);
        chk("lit_t5_rsp_data", longint'(bus.rsp_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("lit_t5_idle_gnt", longint'(bus.gnt), 0);
            chk("lit_t5_idle_rsp", longint'(bus.rsp_valid), 0);
        end
        // idle gap after a single grant
        bus.req_addr = 16'h4521;
        cyc(4'b0100, 4'b0000);
        repeat (3) cyc(4'b0000, 4'b0000);
        settle();
        chk("lit_t6_rsp_valid", longint'(bus.rsp_valid), 0);
        chk("lit_t6_rsp_data", longint'(bus.rsp_data), 32'hDEAD_BEEF);
        chk("lit_t6_rd_sel", longint'(bus.rd_sel), 5);
        // address change while waiting, then a withdrawn request
        cyc(4'b0011, 4'b0000);
        bus.req_addr = 16'h4591;
        cyc(4'b0010, 4'b0000);
        cyc(4'b0110, 4'b0000);
        cyc(4'b0000, 4'b0000);
        repeat (3) cyc(4'b0000, 4'b0000);
        settle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
